// File: rtl/regfile_param_if.sv
// rtl/regfile_param_if.sv - write/read/pending bus between regfile_param and its user
// master drives writes, reads and pending marks; slave returns data, busy flags and READY.
interface regfile_param_if #(
    parameter int AW = 4,
    parameter int DW = 32
);
    logic          WEN1;
    logic [AW-1:0] WA1;
    logic [DW-1:0] DI1;
    logic          WEN2;
    logic [AW-1:0] WA2;
    logic [DW-1:0] DI2;
    logic [AW-1:0] RA0;
    logic [AW-1:0] RA1;
    logic [AW-1:0] RA2;
    logic [DW-1:0] DOUT0;
    logic [DW-1:0] DOUT1;
    logic [DW-1:0] DOUT2;
    logic          PEND_SET;
    logic [AW-1:0] PEND_A;
    logic          BUSY0;
    logic          BUSY1;
    logic          BUSY2;
    logic          READY;

    modport master (
        output WEN1, WA1, DI1, WEN2, WA2, DI2,
        output RA0, RA1, RA2, PEND_SET, PEND_A,
        input  DOUT0, DOUT1, DOUT2, BUSY0, BUSY1, BUSY2, READY
    );

    modport slave (
        input  WEN1, WA1, DI1, WEN2, WA2, DI2,
        input  RA0, RA1, RA2, PEND_SET, PEND_A,
        output DOUT0, DOUT1, DOUT2, BUSY0, BUSY1, BUSY2, READY
    );
endinterface

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - 2-write/3-read register file with self-init and pending scoreboard
// Optional macro REGFILE_BYPASS_EN: forward same-cycle write data and clears to the read ports.
module regfile_param #(
    parameter int            DW      = 32,
    parameter int            NREG    = 15,
    parameter int            AW      = 4,
    parameter int            SP_IDX  = 13,
    parameter logic [DW-1:0] SP_INIT = DW'(32'h00010000)
) (
    input  logic          CLK,
    input  logic          RST,
    regfile_param_if.slave bus
);
    localparam logic [AW:0]   NREG_W = (AW+1)'(NREG);
    localparam logic [AW-1:0] LAST_A = AW'(NREG - 1);
    localparam logic [AW-1:0] SP_A   = AW'(SP_IDX);

    typedef enum logic {INIT, RUN} state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  cnt_q;
    logic [DW-1:0]  regs [NREG];
    logic [NREG-1:0] pend_q, pend_d;

    logic run;
    logic wr1, wr2, pset;

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < NREG_W;
    endfunction

    assign run  = (state_q == RUN);
    assign wr1  = run && bus.WEN1 && in_range(bus.WA1);
    assign wr2  = run && bus.WEN2 && in_range(bus.WA2);
    assign pset = run && bus.PEND_SET && in_range(bus.PEND_A);

    always_comb begin
        state_d = state_q;
        if (state_q == INIT && cnt_q == LAST_A) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == INIT) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Storage has no reset; INIT sweeps every entry before READY rises.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (state_q == INIT) begin
                regs[cnt_q] <= (cnt_q == SP_A) ? SP_INIT : '0;
            end else begin
                if (wr1) begin
                    regs[bus.WA1] <= bus.DI1;
                end
                if (wr2) begin
                    regs[bus.WA2] <= bus.DI2;
                end
            end
        end
    end

    // Clears first, then the set, so a same-cycle set on the same bit wins.
    always_comb begin
        pend_d = pend_q;
        if (wr1) begin
            pend_d[bus.WA1] = 1'b0;
        end
        if (wr2) begin
            pend_d[bus.WA2] = 1'b0;
        end
        if (pset) begin
            pend_d[bus.PEND_A] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    logic [AW-1:0] ra [3];
    logic [DW-1:0] rd [3];
    logic          bz [3];

    assign ra[0] = bus.RA0;
    assign ra[1] = bus.RA1;
    assign ra[2] = bus.RA2;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            rd[i] = '0;
            bz[i] = 1'b0;
            if (run && !RST && in_range(ra[i])) begin
                rd[i] = regs[ra[i]];
                bz[i] = pend_q[ra[i]];
`ifdef REGFILE_BYPASS_EN
                if (wr2 && bus.WA2 == ra[i]) begin
                    rd[i] = bus.DI2;
                end else if (wr1 && bus.WA1 == ra[i]) begin
                    rd[i] = bus.DI1;
                end
                if (((wr1 && bus.WA1 == ra[i]) || (wr2 && bus.WA2 == ra[i])) &&
                    !(pset && bus.PEND_A == ra[i])) begin
                    bz[i] = 1'b0;
                end
`endif
            end
        end
    end

    assign bus.DOUT0 = rd[0];
    assign bus.DOUT1 = rd[1];
    assign bus.DOUT2 = rd[2];
    assign bus.BUSY0 = bz[0];
    assign bus.BUSY1 = bz[1];
    assign bus.BUSY2 = bz[2];
    assign bus.READY = run && !RST;

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - directed self-checking bench for regfile_param
module tb_regfile_param;
    logic CLK = 1'b0;
    logic RST = 1'b1;

    regfile_param_if #(.AW(4), .DW(32)) bus ();

    regfile_param #(
        .DW(32), .NREG(15), .AW(4), .SP_IDX(13), .SP_INIT(32'h00010000)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int passed = 0;
    int total  = 0;
    logic [31:0] model [15];
    logic [14:0] mpend;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        bus.WEN1 = 1'b0; bus.WA1 = '0; bus.DI1 = '0;
        bus.WEN2 = 1'b0; bus.WA2 = '0; bus.DI2 = '0;
        bus.PEND_SET = 1'b0; bus.PEND_A = '0;
    endtask

    task automatic model_init();
        for (int i = 0; i < 15; i++) model[i] = 32'h0;
        model[13] = 32'h00010000;
        mpend = '0;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 15; i++) begin
            bus.RA0 = 4'(i);
            #2;
            check($sformatf("%s_r%0d", tag, i), bus.DOUT0, model[i]);
            check($sformatf("%s_b%0d", tag, i), {31'b0, bus.BUSY0}, {31'b0, mpend[i]});
            tick();
        end
    endtask

    initial begin
        idle();
        bus.RA0 = 4'd13; bus.RA1 = '0; bus.RA2 = '0;
        tick();
        check("rst_ready", {31'b0, bus.READY}, 32'h0);
        check("rst_dout0", bus.DOUT0, 32'h0);
        check("rst_busy0", {31'b0, bus.BUSY0}, 32'h0);
        RST = 1'b0;

        // INIT sweep; writes and pending marks issued mid-INIT must be dropped
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (k == 6) begin
                bus.WEN1 = 1'b1; bus.WA1 = 4'd3;  bus.DI1 = 32'hDEAD0003;
                bus.WEN2 = 1'b1; bus.WA2 = 4'd13; bus.DI2 = 32'hBEEF000D;
                bus.PEND_SET = 1'b1; bus.PEND_A = 4'd3;
            end
            if (k == 13) idle();
            if (k == 14) begin
                check("init_ready14", {31'b0, bus.READY}, 32'h0);
                check("init_dout0", bus.DOUT0, 32'h0);
            end
            if (k == 15) begin
                check("init_ready15", {31'b0, bus.READY}, 32'h1);
                check("run_sp", bus.DOUT0, 32'h00010000);
            end
        end
        model_init();
        check_all("post_init");

        // both ports hit R3: port 2 wins
        bus.RA0 = 4'd3;
        bus.WEN1 = 1'b1; bus.WA1 = 4'd3; bus.DI1 = 32'hAAAA0000;
        bus.WEN2 = 1'b1; bus.WA2 = 4'd3; bus.DI2 = 32'h5555FFFF;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("dual_same_cycle", bus.DOUT0, 32'h5555FFFF);
`else
        check("dual_same_cycle", bus.DOUT0, 32'h0);
`endif
        tick(); idle();
        check("dual_port2_wins", bus.DOUT0, 32'h5555FFFF);
        model[3] = 32'h5555FFFF;

        // distinct addresses on both ports
        bus.WEN1 = 1'b1; bus.WA1 = 4'd6; bus.DI1 = 32'h00000011;
        bus.WEN2 = 1'b1; bus.WA2 = 4'd7; bus.DI2 = 32'h00000022;
        tick(); idle();
        bus.RA1 = 4'd6; bus.RA2 = 4'd7; #1;
        check("dual_r6", bus.DOUT1, 32'h00000011);
        check("dual_r7", bus.DOUT2, 32'h00000022);
        model[6] = 32'h11; model[7] = 32'h22;

        // pending set, write clear, and set beating clear
        bus.RA1 = 4'd5;
        bus.PEND_SET = 1'b1; bus.PEND_A = 4'd5;
        #1;
        check("pend_no_fwd", {31'b0, bus.BUSY1}, 32'h0);
        tick(); idle();
        check("pend_set", {31'b0, bus.BUSY1}, 32'h1);
        bus.WEN2 = 1'b1; bus.WA2 = 4'd5; bus.DI2 = 32'h7;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("pend_clr_same", {31'b0, bus.BUSY1}, 32'h0);
`else
        check("pend_clr_same", {31'b0, bus.BUSY1}, 32'h1);
`endif
        tick(); idle();
        check("pend_clr", {31'b0, bus.BUSY1}, 32'h0);
        check("pend_clr_data", bus.DOUT1, 32'h7);
        bus.PEND_SET = 1'b1; bus.PEND_A = 4'd5;
        bus.WEN1 = 1'b1; bus.WA1 = 4'd5; bus.DI1 = 32'h8;
        tick(); idle();
        check("pend_set_wins", {31'b0, bus.BUSY1}, 32'h1);
        check("pend_set_wins_data", bus.DOUT1, 32'h8);
        model[5] = 32'h8; mpend[5] = 1'b1;

        // read-during-write on R2
        bus.RA0 = 4'd2;
        bus.WEN1 = 1'b1; bus.WA1 = 4'd2; bus.DI1 = 32'h1234;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("rdw_same", bus.DOUT0, 32'h1234);
`else
        check("rdw_same", bus.DOUT0, 32'h0);
`endif
        tick(); idle();
        check("rdw_after", bus.DOUT0, 32'h1234);
        model[2] = 32'h1234;

        // out-of-range address 15
        bus.RA2 = 4'd15;
        bus.WEN1 = 1'b1; bus.WA1 = 4'd15; bus.DI1 = 32'hFFFFFFFF;
        bus.PEND_SET = 1'b1; bus.PEND_A = 4'd15;
        #1;
        check("oor_same", bus.DOUT2, 32'h0);
        tick(); idle();
        check("oor_dout2", bus.DOUT2, 32'h0);
        check("oor_busy2", {31'b0, bus.BUSY2}, 32'h0);
        check_all("after_oor");

        // mid-RUN reset
        bus.WEN1 = 1'b1; bus.WA1 = 4'd4; bus.DI1 = 32'h9;
        tick(); idle();
        bus.PEND_SET = 1'b1; bus.PEND_A = 4'd4;
        tick(); idle();
        bus.RA0 = 4'd4; #1;
        check("pre_rst_r4", bus.DOUT0, 32'h9);
        check("pre_rst_b4", {31'b0, bus.BUSY0}, 32'h1);
        RST = 1'b1; #1;
        check("mid_rst_ready", {31'b0, bus.READY}, 32'h0);
        check("mid_rst_dout", bus.DOUT0, 32'h0);
        check("mid_rst_busy", {31'b0, bus.BUSY0}, 32'h0);
        tick();
        RST = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (k == 14) check("re_ready14", {31'b0, bus.READY}, 32'h0);
            if (k == 15) check("re_ready15", {31'b0, bus.READY}, 32'h1);
        end
        check("re_r4", bus.DOUT0, 32'h0);
        check("re_b4", {31'b0, bus.BUSY0}, 32'h0);
        model_init();
        check_all("post_reinit");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 SHALL have parameter DW, default 32, data width in bits.
REQ-002 SHALL have parameter NREG, default 15, number of implemented registers (2..16).
REQ-003 SHALL have parameter AW, default 4, address width; NREG <= 2**AW.
REQ-004 SHALL have parameter SP_IDX, default 13, index of the stack-pointer register.
REQ-005 SHALL have parameter SP_INIT, default 32'h00010000, post-init value of register SP_IDX.
REQ-006 SHALL have ports: CLK in 1, sole clock; RST in 1, synchronous active-high reset.
REQ-007 SHALL have ports: WEN1 in 1, WA1 in AW, DI1 in DW; WEN2 in 1, WA2 in AW, DI2 in DW; these are the two write ports.
REQ-008 SHALL have ports: RA0/RA1/RA2 in AW, read addresses; DOUT0/DOUT1/DOUT2 out DW, read data.
REQ-009 SHALL have ports: PEND_SET in 1, PEND_A in AW, mark register pending; BUSY0/BUSY1/BUSY2 out 1, pending flag of RA0..RA2.
REQ-010 SHALL have port READY out 1, high once initialisation is complete.
REQ-011 SHALL use one clock, CLK, with RST synchronous and active-high, sampled on the rising edge of CLK only.

Function
REQ-012 SHALL implement a two-state controller, INIT and RUN; RST forces INIT and clears the init counter to 0.
REQ-013 In INIT, SHALL write one entry per cycle at address cnt (SP_INIT if cnt==SP_IDX, else 0) and increment cnt; after writing entry NREG-1 it SHALL enter RUN the next cycle.
REQ-014 READY SHALL be 1 only in RUN; it SHALL rise exactly NREG cycles after the first cycle with RST low.
REQ-015 In INIT, SHALL ignore WEN1, WEN2 and PEND_SET, and SHALL drive DOUT0..2=0 and BUSY0..2=0.
REQ-016 In RUN, writes SHALL be synchronous: REG[WAx]<=DIx on the rising edge when WENx=1.
REQ-017 If WEN1 and WEN2 target the same address in one cycle, port 2 SHALL win.
REQ-018 A write or PEND_A with address >= NREG SHALL be ignored; a read with RAn >= NREG SHALL return DOUTn=0 and BUSYn=0.
REQ-019 Reads SHALL be combinational: DOUTn = REG[RAn] with zero latency.
REQ-020 SHALL keep an NREG-bit pending vector; PEND_SET sets bit PEND_A; an accepted write to address a clears bit a.
REQ-021 When a set and a clear target the same bit in one cycle, set SHALL win.
REQ-022 BUSYn SHALL equal the registered pending bit of RAn, with no same-cycle forwarding.
REQ-023 RST asserted mid-operation SHALL abort RUN or INIT, restart INIT at cnt=0 and clear the pending vector.

Reset
REQ-024 While RST=1, outputs SHALL be READY=0, DOUT0..2=0 and BUSY0..2=0.
REQ-025 Register contents SHALL be defined only after INIT completes; the reset itself clears only the state, cnt and the pending vector.

Configuration
REQ-026 With macro REGFILE_BYPASS_EN defined, in RUN DOUTn SHALL forward same-cycle write data when WENx=1 and WAx==RAn (port 2 priority), and BUSYn SHALL be 0 when such a write hits RAn and PEND_SET does not target RAn.
REQ-027 Without REGFILE_BYPASS_EN, DOUTn and BUSYn SHALL reflect stored state only, so new data appears the cycle after the write.

Verification
REQ-028 Bench SHALL check: RST 1 cycle then low, NREG=15 -> READY rises on the 15th cycle; R13=32'h00010000 and all other registers read 0.
REQ-029 Bench SHALL check: WEN1 WA1=3 DI1=32'hAAAA0000 with WEN2 WA2=3 DI2=32'h5555FFFF -> R3=32'h5555FFFF next cycle.
REQ-030 Bench SHALL check: PEND_SET PEND_A=5, RA1=5 -> BUSY1=1 next cycle; WEN2 WA2=5 DI2=7 -> BUSY1=0 and DOUT1=7 after the edge; PEND_SET and write to 5 in the same cycle -> BUSY1 stays 1.
REQ-031 Bench SHALL check: with REGFILE_BYPASS_EN, WEN1 WA1=2 DI1=32'h1234 and RA0=2 in the same cycle -> DOUT0=32'h1234 in that cycle; without it -> DOUT0 shows the old value in that cycle and 32'h1234 after the edge.
REQ-032 Bench SHALL check: WEN1 WA1=15 (NREG=15) and RA2=15 -> no register changes, DOUT2=0; writes during INIT are discarded.
REQ-033 Bench SHALL check: RST pulsed in RUN with R4=9 and bit 4 pending -> READY=0 and BUSY cleared; after 15 cycles READY=1 and R4=0.
